// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: default widths and FSM state encoding.
package pc_gen_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned INC_DEF  = 4;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StFault  = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential incrementer, branch-target adder, trap/branch priority mux
// and redirect-target alignment check. Purely combinational.
module pc_next_sel import pc_gen_pkg::*; #(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned INC        = INC_DEF,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            br_take_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] br_off_i,
    input  logic            trap_take_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] seq_o,
    output logic            redir_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    // Low ALIGN_BITS set; zero when no alignment is required.
    localparam logic [XLEN-1:0] AlignMask = ~({XLEN{1'b1}} << ALIGN_BITS);

    logic [XLEN-1:0] br_target;

    always_comb begin
        seq_o      = pc_i + XLEN'(INC);
        br_target  = br_base_i + br_off_i;
        redir_o    = trap_take_i | br_take_i;
        target_o   = trap_take_i ? trap_vec_i : br_target;
        misalign_o = redir_o && ((target_o & AlignMask) != '0);
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, fetch handshake, trap/branch redirect, halt/resume
// and misaligned-target fault. Optional perf counters are built when PC_PERF_EN is defined.
module pc_gen import pc_gen_pkg::*; #(
    parameter int unsigned     XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int unsigned     INC        = INC_DEF,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter int unsigned     BOOT_DELAY = 2
) (
    input  logic            CLK,
    input  logic            reset,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            br_take_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] br_off_i,
    input  logic            trap_take_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic            misalign_o,
`ifdef PC_PERF_EN
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     redir_cnt_o,
`endif
    output logic [1:0]      state_o
);

    localparam int unsigned CntW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CntW-1:0] BootLast = CntW'(BOOT_DELAY - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
    logic            misalign_q, misalign_d;
    logic            redir_ok;

    logic [XLEN-1:0] seq_pc, target;
    logic            redir, tgt_mis;

    pc_next_sel #(
        .XLEN       (XLEN),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .pc_i        (pc_q),
        .br_take_i   (br_take_i),
        .br_base_i   (br_base_i),
        .br_off_i    (br_off_i),
        .trap_take_i (trap_take_i),
        .trap_vec_i  (trap_vec_i),
        .seq_o       (seq_pc),
        .redir_o     (redir),
        .target_o    (target),
        .misalign_o  (tgt_mis)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        misalign_d = 1'b0;
        redir_ok   = 1'b0;
        unique case (state_q)
            StBoot: begin
                if (boot_cnt_q == BootLast) begin
                    state_d = StRun;
                    pc_d    = RESET_VEC;
                end else begin
                    boot_cnt_d = boot_cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (redir) begin
                    if (tgt_mis) begin
                        state_d    = StFault;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d     = target;
                        redir_ok = 1'b1;
                        state_d  = halt_i ? StHalted : StRun;
                    end
                end else begin
                    // An address accepted this cycle advances pc before a halt takes effect.
                    if (pc_ready_i) pc_d = seq_pc;
                    if (halt_i) state_d = StHalted;
                end
            end
            StHalted: begin
                if (redir) begin
                    if (tgt_mis) begin
                        state_d    = StFault;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d     = target;
                        redir_ok = 1'b1;
                        state_d  = StRun;
                    end
                end else if (resume_i) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                // Trap has mux priority, so target/tgt_mis reflect trap_vec_i here.
                if (trap_take_i) begin
                    if (tgt_mis) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d     = target;
                        redir_ok = 1'b1;
                        state_d  = StRun;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VEC;
            boot_cnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_PERF_EN
    logic [31:0] fetch_cnt_q, redir_cnt_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (pc_valid_o && pc_ready_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redir_ok) redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`endif

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == StRun);
    assign misalign_o = misalign_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] RVEC = 32'h100;
    localparam int unsigned BDLY = 2;
    localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_FAULT = 2'd3;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i = 1'b0;
    logic        br_take_i = 1'b0;
    logic [31:0] br_base_i = '0;
    logic [31:0] br_off_i = '0;
    logic        trap_take_i = 1'b0;
    logic [31:0] trap_vec_i = '0;
    logic        halt_i = 1'b0;
    logic        resume_i = 1'b0;
    logic        misalign_o;
    logic [1:0]  state_o;
`ifdef PC_PERF_EN
    logic [31:0] fetch_cnt_o, redir_cnt_o;
`endif

    pc_gen #(
        .XLEN       (32),
        .RESET_VEC  (RVEC),
        .INC        (4),
        .ALIGN_BITS (2),
        .BOOT_DELAY (BDLY)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .pc_o        (pc_o),
        .pc_valid_o  (pc_valid_o),
        .pc_ready_i  (pc_ready_i),
        .br_take_i   (br_take_i),
        .br_base_i   (br_base_i),
        .br_off_i    (br_off_i),
        .trap_take_i (trap_take_i),
        .trap_vec_i  (trap_vec_i),
        .halt_i      (halt_i),
        .resume_i    (resume_i),
        .misalign_o  (misalign_o),
`ifdef PC_PERF_EN
        .fetch_cnt_o (fetch_cnt_o),
        .redir_cnt_o (redir_cnt_o),
`endif
        .state_o     (state_o)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Behavioural model
    logic [1:0]  m_state;
    logic [31:0] m_pc;
    int          m_boot;
    bit          m_mis;
    logic [31:0] m_fetch, m_redir;

    task automatic model_reset();
        m_state = S_BOOT;
        m_pc    = RVEC;
        m_boot  = 0;
        m_mis   = 1'b0;
        m_fetch = '0;
        m_redir = '0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          want, ok;
        want = trap_take_i || br_take_i;
        tgt  = trap_take_i ? trap_vec_i : br_base_i + br_off_i;
        ok   = (tgt % 4) == 0;
        m_mis = 1'b0;
        if (m_state == S_RUN && pc_ready_i) m_fetch = m_fetch + 1;
        case (m_state)
            S_BOOT: begin
                m_boot = m_boot + 1;
                if (m_boot == BDLY) begin
                    m_state = S_RUN;
                    m_pc    = RVEC;
                end
            end
            S_RUN, S_HALT: begin
                if (want && !ok) begin
                    m_mis   = 1'b1;
                    m_state = S_FAULT;
                end else if (want) begin
                    m_pc    = tgt;
                    m_redir = m_redir + 1;
                    m_state = (m_state == S_RUN && halt_i) ? S_HALT : S_RUN;
                end else if (m_state == S_RUN) begin
                    if (pc_ready_i) m_pc = m_pc + 4;
                    if (halt_i) m_state = S_HALT;
                end else if (resume_i) begin
                    m_state = S_RUN;
                end
            end
            default: begin
                if (trap_take_i && (trap_vec_i % 4) == 0) begin
                    m_pc    = trap_vec_i;
                    m_redir = m_redir + 1;
                    m_state = S_RUN;
                end else if (trap_take_i) begin
                    m_mis = 1'b1;
                end
            end
        endcase
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            n_tests++;
            if (pc_o !== m_pc || pc_valid_o !== (m_state == S_RUN) || misalign_o !== m_mis
                || state_o !== m_state) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got pc=%h valid=%b mis=%b state=%0d exp pc=%h valid=%b mis=%b state=%0d",
                         $time, pc_o, pc_valid_o, misalign_o, state_o,
                         m_pc, (m_state == S_RUN), m_mis, m_state);
            end
`ifdef PC_PERF_EN
            n_tests++;
            if (fetch_cnt_o !== m_fetch || redir_cnt_o !== m_redir) begin
                n_fail++;
                $display("FAIL perf_cmp t=%0t got fetch=%0d redir=%0d exp fetch=%0d redir=%0d",
                         $time, fetch_cnt_o, redir_cnt_o, m_fetch, m_redir);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input bit rdy, input bit br, input logic [31:0] base,
                        input logic [31:0] off, input bit trap, input logic [31:0] vec,
                        input bit hlt, input bit res);
        pc_ready_i  = rdy;
        br_take_i   = br;
        br_base_i   = base;
        br_off_i    = off;
        trap_take_i = trap;
        trap_vec_i  = vec;
        halt_i      = hlt;
        resume_i    = res;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle(input bit rdy);
        step(rdy, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic branch(input bit rdy, input logic [31:0] base, input logic [31:0] off);
        step(rdy, 1'b1, base, off, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset_pc", pc_o, RVEC);
        chk("reset_valid", 32'(pc_valid_o), 32'd0);
        chk("reset_state", 32'(state_o), 32'(S_BOOT));
        reset = 1'b0;
        check_en = 1'b1;

        // Boot: two cycles invalid, then RESET_VEC
        chk("boot_valid_c1", 32'(pc_valid_o), 32'd0);
        idle(1'b1);
        chk("boot_valid_c2", 32'(pc_valid_o), 32'd0);
        idle(1'b1);
        chk("boot_first_pc", pc_o, 32'h100);
        chk("boot_first_valid", 32'(pc_valid_o), 32'd1);
        idle(1'b1);
        chk("seq_104", pc_o, 32'h104);
        idle(1'b1);
        chk("seq_108", pc_o, 32'h108);

        // Stall, then backward branch during the stall
        branch(1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("stall_hold", pc_o, 32'h200);
        end
        branch(1'b0, 32'h200, 32'hFFFF_FFF0);
        chk("br_neg_off", pc_o, 32'h1F0);

        // Trap beats branch; sequential wrap
        step(1'b1, 1'b1, 32'h1000, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        chk("trap_prio", pc_o, 32'h80);
        branch(1'b0, 32'hFFFF_FFFC, 32'h0);
        idle(1'b1);
        chk("wrap", pc_o, 32'h0);

        // Halt with accept, then resume
        branch(1'b0, 32'h300, 32'h0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("halt_pc", pc_o, 32'h304);
        chk("halt_valid", 32'(pc_valid_o), 32'd0);
        chk("halt_state", 32'(state_o), 32'(S_HALT));
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("resume_pc", pc_o, 32'h304);
        chk("resume_valid", 32'(pc_valid_o), 32'd1);

        // Misaligned branch -> FAULT; only an aligned trap leaves
        branch(1'b1, 32'h400, 32'h2);
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_state", 32'(state_o), 32'(S_FAULT));
        chk("mis_pc_hold", pc_o, 32'h304);
        idle(1'b1);
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);
        step(1'b1, 1'b1, 32'h400, 32'h0, 1'b0, '0, 1'b0, 1'b1);
        chk("fault_ignore", 32'(state_o), 32'(S_FAULT));
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'h80, 1'b0, 1'b0);
        chk("fault_exit_state", 32'(state_o), 32'(S_RUN));
        chk("fault_exit_pc", pc_o, 32'h80);

        // Asynchronous reset mid-RUN
        branch(1'b0, 32'h500, 32'h0);
        chk("pre_reset_pc", pc_o, 32'h500);
        idle(1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", pc_o, RVEC);
        chk("async_rst_valid", 32'(pc_valid_o), 32'd0);
`ifdef PC_PERF_EN
        chk("async_rst_fetch", fetch_cnt_o, 32'd0);
        chk("async_rst_redir", redir_cnt_o, 32'd0);
`endif
        model_reset();
        repeat (2) @(negedge CLK);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, a, b & 32'hFFFF_FFFC,
                 $urandom_range(0, 14) == 0, b, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) == 0);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator; successor to the fixed 32-bit PC register, incrementer and branch-target adder.
- Merges all three into one sequenced block.
- Adds a boot delay, a valid/ready fetch handshake, prioritised trap/branch redirect, halt/resume and misaligned-target detection.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
XLEN, 32, address width in bits
RESET_VEC, 0, PC value presented after boot
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero
BOOT_DELAY, 2, cycles held in BOOT after reset release (minimum 1)

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_o  output  XLEN  current fetch address
pc_valid_o  output  1  pc_o is valid for fetch
pc_ready_i  input  1  fetch accepts pc_o this cycle
br_take_i  input  1  branch/jump redirect request
br_base_i  input  XLEN  branch base address
br_off_i  input  XLEN  branch offset, two's complement
trap_take_i  input  1  trap redirect request
trap_vec_i  input  XLEN  trap target address
halt_i  input  1  stop issuing fetch addresses
resume_i  input  1  leave HALTED sequentially
misalign_o  output  1  one-cycle pulse: misaligned redirect target rejected
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - pc_o=RESET_VEC, pc_valid_o=0, misalign_o=0, state=BOOT, boot counter=0.
  - Reset asserted mid-operation aborts everything immediately.
- FSM encoding: BOOT=0, RUN=1, HALTED=2, FAULT=3.
- BOOT:
  - Counter increments each cycle; pc_valid_o=0; all requests ignored.
  - After BOOT_DELAY cycles, go to RUN with pc_o=RESET_VEC.
- RUN:
  - pc_valid_o=1.
  - Next PC is chosen in priority order: trap_take_i -> trap_vec_i; else br_take_i -> br_base_i+br_off_i; else if pc_ready_i -> pc_o+INC; else hold.
  - All adds are modulo 2^XLEN; wrap from all-ones to low addresses is legal.
  - Redirects apply whether or not pc_ready_i is asserted. An unaccepted pc_o is discarded (flush). New pc_o is visible the next cycle (1-cycle latency).
  - If halt_i=1 with no redirect: go to HALTED and hold pc_o. Any address accepted that cycle still advances pc_o first.
  - If halt_i and a redirect occur together: the redirect wins, then go to HALTED at the target.
- HALTED:
  - pc_valid_o=0; pc_o held.
  - resume_i -> RUN with the same pc_o.
  - trap_take_i or br_take_i -> RUN at the target. Trap is checked before resume.
- Misaligned target (target[ALIGN_BITS-1:0]!=0), checked for both trap and branch targets:
  - pc_o is not updated; misalign_o pulses high for exactly 1 cycle; go to FAULT.
- FAULT:
  - pc_valid_o=0.
  - Only an aligned trap_take_i leaves FAULT, to RUN at trap_vec_i. br_take_i, resume_i and halt_i are ignored.
  - A misaligned trap vector in FAULT re-pulses misalign_o and stays in FAULT.
- pc_o only changes as described above; no glitch from combinational next-PC logic.

Optional Feature:
PC_PERF_EN
- Defined:
  - Adds outputs fetch_cnt_o[31:0] (increments on pc_valid_o&&pc_ready_i) and redir_cnt_o[31:0] (increments on each accepted, aligned redirect).
  - Both reset to 0 and wrap silently.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package (defs header): XLEN default, the FSM state encoding constants, INC default.
- One natural sub-module, pc_next_sel: combinational target adder, priority mux and alignment check.
- pc_gen holds the FSM, registers and counters.

Test Plan:
- Reset release with BOOT_DELAY=2, RESET_VEC=0x100 -> pc_valid_o low for 2 cycles, then pc_o=0x100 valid; with ready held high the sequence is 0x104, 0x108.
- ready low for 3 cycles at pc 0x200 -> pc_o holds 0x200; br_take with base 0x200, off 0xFFFFFFF0 during the stall -> next cycle pc_o=0x1F0.
- trap_take (vec 0x80) and br_take in the same cycle -> pc_o=0x80; pc=0xFFFFFFFC with ready -> pc_o=0x0 (wrap).
- halt_i at pc 0x300 with ready -> HALTED, pc_o=0x304, valid 0; resume_i -> RUN, valid 1, pc_o=0x304.
- br_take to 0x402 -> misalign_o one-cycle pulse, state FAULT, pc_o unchanged; br_take and resume ignored; trap to 0x80 -> RUN at 0x80.
- Assert reset mid-RUN at pc 0x500 -> pc_o=RESET_VEC, valid 0 immediately (asynchronous); with PC_PERF_EN, both counters read 0.
